// File: rtl/cache_ctrl_pkg.sv
// Shared types and constants for the cache miss controller: FSM states,
// victim-info field positions and the latched CPU operation.
package cache_ctrl_pkg;

   localparam int ADDR_W = 4;
   localparam int DATA_W = 8;

   localparam int WB_W       = 14;
   localparam int WB_VALID   = 13;
   localparam int WB_DIRTY   = 12;
   localparam int WB_ADDR_HI = 11;
   localparam int WB_ADDR_LO = 8;
   localparam int WB_DATA_HI = 7;
   localparam int WB_DATA_LO = 0;

   typedef enum logic [2:0] {
      IDLE,
      PROBE,
      CHECK,
      WB,
      FILL,
      INSTALL,
      WRITE,
      RESP
   } state_e;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } cpu_op_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } victim_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low clear; holds at all-ones.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clock,
   input  logic         clear_n,
   input  logic         inc,
   output logic [W-1:0] count
);

   // NOTE: sequential state is updated with non-blocking assignments only.
   always_ff @(posedge clock) begin
      if (!clear_n) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/cache_miss_controller.sv
// Sequencer between a CPU port, a 2-way set-associative array and main memory:
// probe, optional dirty write-back, fill on read miss, install, respond.
module cache_miss_controller
   import cache_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ready,
   output logic              cpu_err,
   output logic              cpu_busy,
   output logic              cache_req,
   output logic              cache_we,
   output logic              cache_fill,
   output logic [ADDR_W-1:0] cache_addr,
   output logic [DATA_W-1:0] cache_din,
   input  logic              cache_hit,
   input  logic [DATA_W-1:0] cache_dout,
   input  logic [WB_W-1:0]   cache_wb,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic [CNT_W-1:0]  hit_count,
   output logic [CNT_W-1:0]  miss_count,
   output logic              err_sticky
);

   localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

   state_e            state, state_n;
   cpu_op_t           op, op_n;
   victim_t           victim, victim_n;
   logic [DATA_W-1:0] fill_data, fill_n;
   logic [DATA_W-1:0] resp_data, resp_n;
   logic              err_flag, err_n;
   logic [7:0]        tmo, tmo_n;
   logic              mem_wait, expired;
   logic              hit_inc, miss_inc;

   logic              cache_req_n, cache_we_n, cache_fill_n;
   logic [ADDR_W-1:0] cache_addr_n, mem_addr_n;
   logic [DATA_W-1:0] cache_din_n, mem_wdata_n, cpu_rdata_n;
   logic              mem_req_n, mem_we_n, cpu_ready_n, cpu_err_n, cpu_busy_n;

   // NOTE: every variable gets a default before the case so no latch is inferred.
   always_comb begin
      state_n  = state;
      op_n     = op;
      victim_n = victim;
      fill_n   = fill_data;
      resp_n   = resp_data;
      err_n    = err_flag;
      hit_inc  = 1'b0;
      miss_inc = 1'b0;
      mem_wait = (state == WB) || (state == FILL);
      expired  = mem_wait && !mem_ack && (tmo == TMO_LAST);

      case (state)
         IDLE: begin
            if (cpu_req) begin
               op_n.we    = cpu_we;
               op_n.addr  = cpu_addr;
               op_n.wdata = cpu_wdata;
               err_n      = 1'b0;
               resp_n     = '0;
               state_n    = PROBE;
            end
         end
         PROBE: state_n = CHECK;
         CHECK: begin
            victim_n.addr = cache_wb[WB_ADDR_HI:WB_ADDR_LO];
            victim_n.data = cache_wb[WB_DATA_HI:WB_DATA_LO];
            if (cache_hit) begin
               hit_inc = 1'b1;
               if (op.we) begin
                  state_n = WRITE;
               end else begin
                  resp_n  = cache_dout;
                  state_n = RESP;
               end
            end else begin
               miss_inc = 1'b1;
               if (cache_wb[WB_VALID] && cache_wb[WB_DIRTY]) state_n = WB;
               else if (op.we)                               state_n = WRITE;
               else                                          state_n = FILL;
            end
         end
         WB: begin
            if (mem_ack) begin
               state_n = op.we ? WRITE : FILL;
            end else if (expired) begin
               err_n   = 1'b1;
               resp_n  = '0;
               state_n = RESP;
            end
         end
         FILL: begin
            if (mem_ack) begin
               fill_n  = mem_rdata;
               state_n = INSTALL;
            end else if (expired) begin
               err_n   = 1'b1;
               resp_n  = '0;
               state_n = RESP;
            end
         end
         INSTALL: begin
            resp_n  = fill_data;
            state_n = RESP;
         end
         WRITE:   state_n = RESP;
         RESP:    state_n = IDLE;
         default: state_n = IDLE;
      endcase

      // The timeout window restarts on every entry into a memory transaction.
      if ((state_n != state) && ((state_n == WB) || (state_n == FILL))) tmo_n = '0;
      else if (mem_wait)                                                tmo_n = tmo + 8'd1;
      else                                                              tmo_n = tmo;

      // Array and memory strobes are registered from the state being entered.
      cache_req_n  = (state_n == PROBE) || (state_n == INSTALL) || (state_n == WRITE);
      cache_we_n   = (state_n == INSTALL) || (state_n == WRITE);
      cache_fill_n = (state_n == INSTALL);
      cache_addr_n = cache_req_n ? op_n.addr : '0;
      cache_din_n  = (state_n == INSTALL) ? fill_n :
                     (state_n == WRITE)   ? op_n.wdata : '0;
      mem_req_n    = (state_n == WB) || (state_n == FILL);
      mem_we_n     = (state_n == WB);
      mem_addr_n   = (state_n == WB)   ? victim_n.addr :
                     (state_n == FILL) ? op_n.addr : '0;
      mem_wdata_n  = (state_n == WB) ? victim_n.data : '0;
      cpu_busy_n   = (state_n != IDLE);

      // The response pulse is issued from RESP itself, one cycle after entry.
      cpu_ready_n  = (state == RESP);
      cpu_err_n    = (state == RESP) && err_flag;
      cpu_rdata_n  = (state == RESP) ? resp_data : '0;
   end

   // NOTE: reset is synchronous and active-low; it also abandons any access in flight.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state      <= IDLE;
         op         <= '0;
         victim     <= '0;
         fill_data  <= '0;
         resp_data  <= '0;
         err_flag   <= 1'b0;
         tmo        <= '0;
         cache_req  <= 1'b0;
         cache_we   <= 1'b0;
         cache_fill <= 1'b0;
         cache_addr <= '0;
         cache_din  <= '0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         cpu_ready  <= 1'b0;
         cpu_err    <= 1'b0;
         cpu_rdata  <= '0;
         cpu_busy   <= 1'b0;
         err_sticky <= 1'b0;
      end else begin
         state      <= state_n;
         op         <= op_n;
         victim     <= victim_n;
         fill_data  <= fill_n;
         resp_data  <= resp_n;
         err_flag   <= err_n;
         tmo        <= tmo_n;
         cache_req  <= cache_req_n;
         cache_we   <= cache_we_n;
         cache_fill <= cache_fill_n;
         cache_addr <= cache_addr_n;
         cache_din  <= cache_din_n;
         mem_req    <= mem_req_n;
         mem_we     <= mem_we_n;
         mem_addr   <= mem_addr_n;
         mem_wdata  <= mem_wdata_n;
         cpu_ready  <= cpu_ready_n;
         cpu_err    <= cpu_err_n;
         cpu_rdata  <= cpu_rdata_n;
         cpu_busy   <= cpu_busy_n;
         err_sticky <= err_sticky | expired;
      end
   end

   sat_counter #(.W(CNT_W)) u_hit_cnt (
      .clock   (clock),
      .clear_n (reset),
      .inc     (hit_inc),
      .count   (hit_count)
   );

   sat_counter #(.W(CNT_W)) u_miss_cnt (
      .clock   (clock),
      .clear_n (reset),
      .inc     (miss_inc),
      .count   (miss_count)
   );

endmodule

// File: doc/cache_miss_controller.md
Name: cache_miss_controller

Overview:
- Sequencer between CPU request port, 2-way set-associative cache array (4-bit address, 8-bit data, LRU replacement) and 8-bit main memory.
- Probes array; on hit completes the CPU access. On miss: writes back dirty victim, fills on read misses, installs line, responds.
- Provides saturating hit/miss statistics and memory-timeout error reporting.

Parameters:
- MEM_TIMEOUT, 16: max cycles waiting for mem_ack per memory transaction; range 2..255.
- CNT_W, 8: width of hit/miss statistics counters.

Ports:
- clock  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-low; acts on rising edge when 0
- cpu_req  in  1  request; held until cpu_ready
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  4  {tag[3:2], index[1:0]}
- cpu_wdata  in  8  write data
- cpu_rdata  out  8  read data; valid while cpu_ready=1
- cpu_ready  out  1  one-cycle completion pulse
- cpu_err  out  1  qualifies cpu_ready: access aborted by timeout
- cpu_busy  out  1  1 in every state except IDLE
- cache_req  out  1  one-cycle array strobe
- cache_we  out  1  array write (0=probe)
- cache_fill  out  1  with cache_we: install clean (dirty=0)
- cache_addr  out  4  array address
- cache_din  out  8  array write data
- cache_hit  in  1  probe result, valid cycle after strobe
- cache_dout  in  8  probe read data
- cache_wb  in  14  victim info: [13]=valid, [12]=dirty, [11:8]=victim address, [7:0]=victim data
- mem_req  out  1  memory request, held until mem_ack or timeout
- mem_we  out  1  1=write-back, 0=fill read
- mem_addr  out  4  memory address
- mem_wdata  out  8  write-back data
- mem_rdata  in  8  fill data, valid with mem_ack
- mem_ack  in  1  one-cycle memory completion
- hit_count  out  CNT_W  saturating hit counter
- miss_count  out  CNT_W  saturating miss counter
- err_sticky  out  1  set on any timeout, cleared only by reset

Behaviour:
- Reset (reset=0 at edge): state=IDLE; all outputs 0. Mid-operation reset drops mem_req/cache_req at that edge and abandons the access with no cpu_ready.
- All outputs registered. FSM states: IDLE, PROBE, CHECK, WB, FILL, INSTALL, WRITE, RESP.
- IDLE: on cpu_req=1, latch addr/we/wdata -> PROBE. cpu_req is sampled only in IDLE.
- PROBE: cache_req=1, cache_we=0, cache_addr=latched -> CHECK.
- CHECK: sample cache_hit/cache_dout/cache_wb; latch victim.
  - Hit: hit_count++. Read -> RESP with cpu_rdata=cache_dout. Write -> WRITE.
  - Miss: miss_count++. If victim valid&dirty -> WB. Otherwise read -> FILL, write -> WRITE.
- WB: mem_req=1, mem_we=1, mem_addr/mem_wdata=victim. On mem_ack: read -> FILL, write -> WRITE.
- FILL: mem_req=1, mem_we=0, mem_addr=latched. On mem_ack, capture mem_rdata -> INSTALL.
- INSTALL: cache_req=1, cache_we=1, cache_fill=1, cache_din=fill data; cpu_rdata=fill data -> RESP.
- WRITE: cache_req=1, cache_we=1, cache_fill=0, cache_din=latched wdata -> RESP. Write-allocate; no fill (1-word lines).
- RESP: cpu_ready=1 for exactly one cycle -> IDLE. A new request is accepted no earlier than the following IDLE cycle.
- Read-hit latency: request accepted at edge E; cache_req high E..E+1; cpu_ready high E+3..E+4.
- Timeout: counter clears on entry to WB/FILL and increments each cycle without mem_ack.
  - On reaching MEM_TIMEOUT-1: drop mem_req, set err_sticky, go to RESP with cpu_err=1, cpu_rdata=0; no array write.
  - mem_ack in the same cycle as timeout wins (normal path).
- mem_ack outside WB/FILL is ignored.
- Counters saturate at 2^CNT_W-1; no wrap.

Decomposition:
- Package cache_ctrl_pkg: FSM state enum; WB field index constants (WB_VALID=13, WB_DIRTY=12, WB_ADDR_HI/LO=11/8, WB_DATA_HI/LO=7/0); ADDR_W=4, DATA_W=8.
- Sub-module sat_counter (width parameter, inc, sync active-low clear), instantiated for hit and miss counts. Timeout counter stays inline.

Test Plan:
- Read hit: array returns hit=1, dout=0x07 for addr 0xB -> cpu_ready E+3..E+4, cpu_rdata=0x07, no mem_req, hit_count=1.
- Read miss, dirty victim: cache_wb={1,1,4'h5,8'h08}, addr 0x1 -> mem write addr 5 data 0x08; fill mem_rdata=0x3C -> INSTALL cache_fill=1 din=0x3C; cpu_rdata=0x3C; miss_count=1.
- Write miss, clean victim: wdata 0xA5, addr 0xE, wb dirty=0 -> no mem traffic; WRITE din=0xA5 addr 0xE; cpu_ready, cpu_err=0.
- Timeout: MEM_TIMEOUT=4, mem_ack never asserted in FILL -> mem_req drops after 4 cycles; cpu_ready=1, cpu_err=1, err_sticky=1 until reset.
- Reset mid-WB: reset=0 while mem_req=1 -> next edge mem_req=0, IDLE, counters 0, no cpu_ready.
- Saturation: CNT_W=2, five read hits -> hit_count stays 3.
